cu_simple_instr_fetch: RTL and testbench



---
 rtl/cu_simple_instr_fetch.sv | 130 +++++++++++++
 tb/tb_cu_simple_instr_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_simple_instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per instruction
// from a synchronous-read memory and hands it to the decoder.
module cu_simple_instr_fetch #(
    parameter int unsigned PC_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  run,
    output logic                  mem_en,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  raw_instr_valid,
    output logic [DATA_WIDTH-1:0] raw_instr_data,
    input  logic                  raw_instr_ack,
    input  logic                  jump_valid,
    input  logic [DATA_WIDTH-1:0] jump_ptr,
    output logic                  jump_ack,
    input  logic                  branch_valid,
    input  logic [DATA_WIDTH-1:0] branch_ptr,
    output logic                  branch_ack,
    input  logic                  cond_valid,
    input  logic [DATA_WIDTH-1:0] cond_data,
    output logic                  cond_ack,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [31:0]           retired
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  load;
    logic                  consume;
    logic                  fetch;

    // Only the low PC_WIDTH pointer bits and condition bit 0 matter.
    logic unused_bits;
    assign unused_bits = ^{jump_ptr[DATA_WIDTH-1:PC_WIDTH],
                           branch_ptr[DATA_WIDTH-1:PC_WIDTH],
                           cond_data[DATA_WIDTH-1:1]};

    assign pc_inc = pc + PC_WIDTH'(1);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        fetch      = 1'b0;
        load       = 1'b0;
        consume    = 1'b0;
        jump_ack   = 1'b0;
        branch_ack = 1'b0;
        cond_ack   = 1'b0;
        if (resetn) begin
            unique case (state)
                FETCH: begin
                    if (run) begin
                        fetch      = 1'b1;
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    load       = 1'b1;
                    state_next = PRESENT;
                end
                PRESENT: begin
                    if (jump_valid) begin
                        jump_ack   = 1'b1;
                        consume    = 1'b1;
                        pc_next    = jump_ptr[PC_WIDTH-1:0];
                        state_next = FETCH;
                    end else if (branch_valid && cond_valid) begin
                        branch_ack = 1'b1;
                        cond_ack   = 1'b1;
                        consume    = 1'b1;
                        pc_next    = cond_data[0] ?
                                     branch_ptr[PC_WIDTH-1:0] : pc_inc;
                        state_next = FETCH;
                    end else if (branch_valid) begin
                        // waiting on the condition; hold everything
                        state_next = PRESENT;
                    end else if (raw_instr_ack) begin
                        consume    = 1'b1;
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign mem_en   = fetch;
    assign mem_addr = fetch ? pc : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            retired     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load) begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end
            if (consume && (retired != 32'hFFFF_FFFF)) begin
                retired <= retired + 32'd1;
            end
        end
    end

    assign raw_instr_valid = instr_valid;
    assign raw_instr_data  = instr;

endmodule

// File: tb/tb_cu_simple_instr_fetch.sv
// Directed bench for cu_simple_instr_fetch with a synchronous memory model.
module tb_cu_simple_instr_fetch;

    logic        clk;
    logic        resetn;
    logic        run;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        raw_instr_valid;
    logic [31:0] raw_instr_data;
    logic        raw_instr_ack;
    logic        jump_valid;
    logic [31:0] jump_ptr;
    logic        jump_ack;
    logic        branch_valid;
    logic [31:0] branch_ptr;
    logic        branch_ack;
    logic        cond_valid;
    logic [31:0] cond_data;
    logic        cond_ack;
    logic [15:0] pc;
    logic [31:0] retired;

    logic [31:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    cu_simple_instr_fetch #(
        .PC_WIDTH(16),
        .DATA_WIDTH(32),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .run(run),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .raw_instr_valid(raw_instr_valid),
        .raw_instr_data(raw_instr_data),
        .raw_instr_ack(raw_instr_ack),
        .jump_valid(jump_valid),
        .jump_ptr(jump_ptr),
        .jump_ack(jump_ack),
        .branch_valid(branch_valid),
        .branch_ptr(branch_ptr),
        .branch_ack(branch_ack),
        .cond_valid(cond_valid),
        .cond_data(cond_data),
        .cond_ack(cond_ack),
        .pc(pc),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!raw_instr_valid && n < max_cycles) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (raw_instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid timeout got %b exp 1", raw_instr_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; run = 1'b1;
        raw_instr_ack = 1'b0;
        jump_valid = 1'b1; jump_ptr = 32'h1234;
        branch_valid = 1'b1; branch_ptr = 32'h5678;
        cond_valid = 1'b1; cond_data = 32'h1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++;
            $display("FAIL rst_mem_en got %b exp 0", mem_en); end
        checks++; if (mem_addr !== 16'h0) begin errors++;
            $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (raw_instr_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b exp 0", raw_instr_valid); end
        checks++; if (raw_instr_data !== 32'h0) begin errors++;
            $display("FAIL rst_data got %h exp 0", raw_instr_data); end
        checks++; if ({jump_ack, branch_ack, cond_ack} !== 3'b000) begin
            errors++; $display("FAIL rst_acks got %b exp 000",
                               {jump_ack, branch_ack, cond_ack}); end
        checks++; if (pc !== 16'h0) begin errors++;
            $display("FAIL rst_pc got %h exp 0", pc); end
        checks++; if (retired !== 32'h0) begin errors++;
            $display("FAIL rst_retired got %0d exp 0", retired); end
        jump_valid = 1'b0; branch_valid = 1'b0; cond_valid = 1'b0;
        cond_data = 32'h0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_words [3];
        int k;
        logic exp_valid;
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        k = 0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0) begin errors++;
            $display("FAIL seq_first_fetch got en=%b addr=%h exp 1/0000",
                     mem_en, mem_addr); end
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            raw_instr_ack = 1'b0;
            #1;
            exp_valid = (cyc == 2 || cyc == 5 || cyc == 8);
            checks++; if (raw_instr_valid !== exp_valid) begin errors++;
                $display("FAIL seq_valid_c%0d got %b exp %b",
                         cyc, raw_instr_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (raw_instr_data !== exp_words[k]) begin
                    errors++; $display("FAIL seq_data_%0d got %h exp %h",
                                       k, raw_instr_data, exp_words[k]); end
                raw_instr_ack = 1'b1;
                k++;
            end
        end
        checks++; if (pc !== 16'h3) begin errors++;
            $display("FAIL seq_pc got %h exp 0003", pc); end
        checks++; if (retired !== 32'd3) begin errors++;
            $display("FAIL seq_retired got %0d exp 3", retired); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3) begin errors++;
            $display("FAIL seq_next_fetch got en=%b addr=%h exp 1/0003",
                     mem_en, mem_addr); end
    endtask

    task automatic test_jump();
        wait_valid(10);
        raw_instr_ack = 1'b1;
        @(negedge clk);
        raw_instr_ack = 1'b0;
        #1;
        wait_valid(10);
        checks++; if (raw_instr_data !== 32'h55) begin errors++;
            $display("FAIL jump_word4 got %h exp 00000055", raw_instr_data); end
        jump_valid = 1'b1; jump_ptr = 32'h0001_0020;
        branch_valid = 1'b1; branch_ptr = 32'h99;
        cond_valid = 1'b1; cond_data = 32'h1;
        #1;
        checks++; if (jump_ack !== 1'b1) begin errors++;
            $display("FAIL jump_ack got %b exp 1", jump_ack); end
        checks++; if (branch_ack !== 1'b0 || cond_ack !== 1'b0) begin
            errors++; $display("FAIL jump_prio got br=%b cond=%b exp 0/0",
                               branch_ack, cond_ack); end
        @(negedge clk);
        jump_valid = 1'b0; branch_valid = 1'b0; cond_valid = 1'b0;
        cond_data = 32'h0;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0020) begin
            errors++; $display("FAIL jump_target got en=%b addr=%h exp 1/0020",
                               mem_en, mem_addr); end
        checks++; if (retired !== 32'd5) begin errors++;
            $display("FAIL jump_retired got %0d exp 5", retired); end
        checks++; if (raw_instr_valid !== 1'b0) begin errors++;
            $display("FAIL jump_valid_drop got %b exp 0", raw_instr_valid); end
    endtask

    task automatic test_branch();
        wait_valid(10);
        checks++; if (raw_instr_data !== 32'hB0) begin errors++;
            $display("FAIL br_word got %h exp 000000b0", raw_instr_data); end
        branch_valid = 1'b1; branch_ptr = 32'h40; cond_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (branch_ack !== 1'b0 || cond_ack !== 1'b0) begin
                errors++; $display("FAIL br_stall_ack_%0d got %b%b exp 00",
                                   i, branch_ack, cond_ack); end
            checks++; if (raw_instr_valid !== 1'b1 ||
                          raw_instr_data !== 32'hB0) begin errors++;
                $display("FAIL br_stall_data_%0d got %b/%h exp 1/000000b0",
                         i, raw_instr_valid, raw_instr_data); end
            @(negedge clk);
        end
        cond_valid = 1'b1; cond_data = 32'h1;
        #1;
        checks++; if (branch_ack !== 1'b1 || cond_ack !== 1'b1) begin
            errors++; $display("FAIL br_taken_ack got %b%b exp 11",
                               branch_ack, cond_ack); end
        @(negedge clk);
        branch_valid = 1'b0; cond_valid = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin
            errors++; $display("FAIL br_taken_addr got en=%b addr=%h exp 1/0040",
                               mem_en, mem_addr); end
        checks++; if (retired !== 32'd6) begin errors++;
            $display("FAIL br_taken_retired got %0d exp 6", retired); end
        wait_valid(10);
        branch_valid = 1'b1; branch_ptr = 32'h80;
        cond_valid = 1'b1; cond_data = 32'hFFFF_FFFE;
        #1;
        checks++; if (branch_ack !== 1'b1 || cond_ack !== 1'b1) begin
            errors++; $display("FAIL br_nt_ack got %b%b exp 11",
                               branch_ack, cond_ack); end
        @(negedge clk);
        branch_valid = 1'b0; cond_valid = 1'b0; cond_data = 32'h0;
        #1;
        checks++; if (mem_addr !== 16'h0041 || pc !== 16'h0041) begin
            errors++; $display("FAIL br_nt_addr got addr=%h pc=%h exp 0041",
                               mem_addr, pc); end
        wait_valid(10);
        cond_valid = 1'b1; cond_data = 32'h1;
        #1;
        checks++; if (cond_ack !== 1'b0 || branch_ack !== 1'b0) begin
            errors++; $display("FAIL cond_alone_ack got %b%b exp 00",
                               branch_ack, cond_ack); end
        raw_instr_ack = 1'b1;
        @(negedge clk);
        raw_instr_ack = 1'b0; cond_valid = 1'b0; cond_data = 32'h0;
        #1;
        checks++; if (mem_addr !== 16'h0042 || retired !== 32'd8) begin
            errors++; $display("FAIL plain_ack got addr=%h ret=%0d exp 0042/8",
                               mem_addr, retired); end
    endtask

    task automatic test_wrap_and_stall();
        wait_valid(10);
        jump_valid = 1'b1; jump_ptr = 32'h0000_FFFF;
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 16'hFFFF) begin errors++;
            $display("FAIL wrap_jump got %h exp ffff", mem_addr); end
        wait_valid(10);
        checks++; if (raw_instr_data !== 32'hEE) begin errors++;
            $display("FAIL wrap_word got %h exp 000000ee", raw_instr_data); end
        raw_instr_ack = 1'b1; run = 1'b0;
        @(negedge clk);
        raw_instr_ack = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000 || retired !== 32'd10) begin errors++;
            $display("FAIL wrap_pc got pc=%h ret=%0d exp 0000/10",
                     pc, retired); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++; if (mem_en !== 1'b0 || raw_instr_valid !== 1'b0) begin
                errors++; $display("FAIL stall_%0d got en=%b v=%b exp 0/0",
                                   i, mem_en, raw_instr_valid); end
        end
        @(negedge clk);
        run = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL stall_resume got en=%b addr=%h exp 1/0000",
                               mem_en, mem_addr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (raw_instr_valid !== 1'b1 ||
                      raw_instr_data !== 32'h11) begin errors++;
            $display("FAIL stall_latency got %b/%h exp 1/00000011",
                     raw_instr_valid, raw_instr_data); end
        raw_instr_ack = 1'b1;
        @(negedge clk);
        raw_instr_ack = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        #1;
        wait_valid(10);
        jump_valid = 1'b1; jump_ptr = 32'h0100;
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++; $display("FAIL rml_fetch got en=%b addr=%h exp 1/0100",
                               mem_en, mem_addr); end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (pc !== 16'h0 || retired !== 32'h0) begin errors++;
            $display("FAIL rml_state got pc=%h ret=%0d exp 0000/0",
                     pc, retired); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0) begin errors++;
            $display("FAIL rml_restart got en=%b addr=%h exp 1/0000",
                     mem_en, mem_addr); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            checks++; if (raw_instr_valid === 1'b1 &&
                          raw_instr_data === 32'hDEAD) begin errors++;
                $display("FAIL rml_dead_c%0d got %h exp not 0000dead",
                         c, raw_instr_data); end
        end
        checks++; if (raw_instr_valid !== 1'b1 ||
                      raw_instr_data !== 32'h11) begin errors++;
            $display("FAIL rml_first got %b/%h exp 1/00000011",
                     raw_instr_valid, raw_instr_data); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'hC0DE_0000 | a;
        mem[16'h0000] = 32'h11;
        mem[16'h0001] = 32'h22;
        mem[16'h0002] = 32'h33;
        mem[16'h0003] = 32'h44;
        mem[16'h0004] = 32'h55;
        mem[16'h0020] = 32'hB0;
        mem[16'h0040] = 32'hC0;
        mem[16'hFFFF] = 32'hEE;
        mem[16'h0100] = 32'hDEAD;
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_wrap_and_stall();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
